// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, IF/ID buffer and EX redirect.
// The master modport is the fetch sequencer; the slave modport is its environment.
interface fetch_ctrl_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_pc,
        input  id_ready,
        input  redirect_valid, redirect_base, redirect_imm,
        output fetch_fault
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_pc,
        output id_ready,
        output redirect_valid, redirect_base, redirect_imm,
        input  fetch_fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one request in flight, buffers IF/ID.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap to FAULT instead of being word-aligned.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_RESET_IDLE = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT       = 3'd2,
        ST_HOLD       = 3'd3,
        ST_DRAIN      = 3'd4
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_FAULT      = 3'd5
`endif
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_req_valid;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_fault;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_req_pc_next;
    logic        w_if_valid_next;
    logic [31:0] w_if_instr_next;
    logic [31:0] w_if_pc_next;
    logic        w_handshake;
    logic [31:0] w_target;
    logic [31:0] w_redirect_pc;

    assign w_handshake   = r_req_valid && bus.imem_req_ready;
    assign w_target      = bus.redirect_base + bus.redirect_imm;
    assign w_redirect_pc = w_target & ~32'h0000_0003;

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_req_pc_next   = r_req_pc;
        w_if_valid_next = r_if_valid;
        w_if_instr_next = r_if_instr;
        w_if_pc_next    = r_if_pc;

        case (r_state)
            ST_RESET_IDLE: begin
                w_state_next = ST_REQ;
                if (bus.redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end
            end
            ST_REQ: begin
                if (bus.redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                    // An accepted request in the redirect cycle is wrong-path; its response must be eaten.
                    if (w_handshake) begin
                        w_state_next = ST_DRAIN;
                    end
                end else if (w_handshake) begin
                    w_state_next  = ST_WAIT;
                    w_req_pc_next = r_pc;
                    w_pc_next     = r_pc + 32'd4;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    w_pc_next    = w_redirect_pc;
                    w_state_next = bus.imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (bus.imem_rsp_valid) begin
                    w_if_instr_next = bus.imem_rsp_data;
                    w_if_pc_next    = r_req_pc;
                    w_if_valid_next = 1'b1;
                    w_state_next    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.redirect_valid) begin
                    w_pc_next       = w_redirect_pc;
                    w_if_valid_next = 1'b0;
                    w_state_next    = ST_REQ;
                end else if (bus.id_ready) begin
                    w_if_valid_next = 1'b0;
                    w_state_next    = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (bus.redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end else if (bus.imem_rsp_valid) begin
                    w_state_next = ST_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
`endif
            default: begin
                w_state_next = ST_RESET_IDLE;
            end
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        // A misaligned target overrides every state decision above; the PC keeps its aligned value.
        if (bus.redirect_valid && (w_target[1:0] != 2'b00) && (r_state != ST_FAULT)) begin
            w_state_next    = ST_FAULT;
            w_pc_next       = r_pc;
            w_if_valid_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET_IDLE;
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_req_valid <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_instr  <= NOP_INSTR;
            r_if_pc     <= 32'h0000_0000;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_req_pc    <= w_req_pc_next;
            r_req_valid <= (w_state_next == ST_REQ);
            r_if_valid  <= w_if_valid_next;
            r_if_instr  <= w_if_instr_next;
            r_if_pc     <= w_if_pc_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_fault     <= (w_state_next == ST_FAULT);
`else
            r_fault     <= 1'b0;
`endif
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = r_if_valid;
    assign bus.if_instr       = r_if_instr;
    assign bus.if_pc          = r_if_pc;
    assign bus.fetch_fault    = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level model (next fetch address, one outstanding
// request with a wrong-path flag, IF/ID buffer) checked every cycle, plus literal expectations.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_out_addr;
    logic        m_buf_valid;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    logic        m_fault;
    logic        m_started;
    logic        m_req_exp;
    logic        m_hs;
    logic [31:0] m_tgt;

    // A request is offered whenever the sequencer is running, idle on the bus and the buffer is empty.
    assign m_req_exp = m_started && !m_out && !m_buf_valid && !m_fault;
    assign m_hs      = m_req_exp && bus.imem_req_ready;
    assign m_tgt     = bus.redirect_base + bus.redirect_imm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc        <= RESET_PC;
            m_out       <= 1'b0;
            m_stale     <= 1'b0;
            m_out_addr  <= 32'h0;
            m_buf_valid <= 1'b0;
            m_buf_pc    <= 32'h0;
            m_buf_instr <= 32'h0000_0013;
            m_fault     <= 1'b0;
            m_started   <= 1'b0;
        end else begin
            m_started <= 1'b1;
            if (m_fault) begin
                m_fault <= 1'b1;
            end else if (bus.redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (m_tgt[1:0] != 2'b00) begin
                    m_fault     <= 1'b1;
                    m_buf_valid <= 1'b0;
                    m_out       <= 1'b0;
                end else
`endif
                begin
                    m_pc        <= {m_tgt[31:2], 2'b00};
                    m_buf_valid <= 1'b0;
                    if (m_hs) begin
                        m_out   <= 1'b1;
                        m_stale <= 1'b1;
                    end else if (m_out && !m_stale && bus.imem_rsp_valid) begin
                        m_out <= 1'b0;
                    end else if (m_out) begin
                        m_stale <= 1'b1;
                    end
                end
            end else if (m_hs) begin
                m_out      <= 1'b1;
                m_stale    <= 1'b0;
                m_out_addr <= m_pc;
                m_pc       <= m_pc + 32'd4;
            end else if (m_out && bus.imem_rsp_valid) begin
                m_out <= 1'b0;
                if (!m_stale) begin
                    m_buf_valid <= 1'b1;
                    m_buf_pc    <= m_out_addr;
                    m_buf_instr <= bus.imem_rsp_data;
                end
            end else if (m_buf_valid && bus.id_ready) begin
                m_buf_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("req_valid", {31'h0, bus.imem_req_valid}, {31'h0, m_req_exp});
        if (m_req_exp || !m_started) begin
            chk("req_addr", bus.imem_req_addr, m_pc);
        end
        chk("if_valid", {31'h0, bus.if_valid}, {31'h0, m_buf_valid});
        chk("if_pc", bus.if_pc, m_buf_pc);
        chk("if_instr", bus.if_instr, m_buf_instr);
        chk("fetch_fault", {31'h0, bus.fetch_fault}, {31'h0, m_fault});
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rd, input bit idr,
                        input bit rdir, input logic [31:0] base, input logic [31:0] imm);
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rd;
        bus.id_ready       = idr;
        bus.redirect_valid = rdir;
        bus.redirect_base  = base;
        bus.redirect_imm   = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic redirect(input bit rdy, input bit rv, input logic [31:0] base, input logic [31:0] imm);
        $display("redirect base=%h imm=%h ready=%0b rsp_valid=%0b", base, imm, rdy, rv);
        step(rdy, rv, 32'hDEAD_BEEF, 1'b0, 1'b1, base, imm);
    endtask

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        chk("lit_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("lit_req_addr", bus.imem_req_addr, addr);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_if_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("lit_if_pc", bus.if_pc, addr);
        chk("lit_if_instr", bus.if_instr, data);
        $display("fetch addr=%h instr=%h", bus.if_pc, bus.if_instr);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_base  = 32'h0;
        bus.redirect_imm   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("rst_if_instr", bus.if_instr, 32'h0000_0013);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        rst_n = 1'b1;
        chk("idle_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        idle();

        // Stall in HOLD: first instruction at 0x100 held for five cycles.
        chk("first_req_addr", bus.imem_req_addr, 32'h0000_0100);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) idle();
        chk("stall_if_valid", {31'h0, bus.if_valid}, 32'h1);
        chk("stall_if_instr", bus.if_instr, 32'h0050_0093);
        chk("stall_if_pc", bus.if_pc, 32'h0000_0100);
        chk("stall_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        $display("fetch addr=%h instr=%h (after stall)", bus.if_pc, bus.if_instr);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("post_stall_addr", bus.imem_req_addr, 32'h0000_0104);
        fetch_one(32'h0000_0104, 32'h0010_0113);
        fetch_one(32'h0000_0108, 32'h0020_0193);

        // Redirect while waiting: response of 0x10C is wrong-path.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        redirect(1'b0, 1'b0, 32'h0000_0200, 32'hFFFF_FFF0);
        chk("drain_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        step(1'b0, 1'b1, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("drain_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("drain_next_addr", bus.imem_req_addr, 32'h0000_01F0);
        fetch_one(32'h0000_01F0, 32'h1230_0093);

        // Redirect coincident with a response.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        redirect(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0020);
        chk("coinc_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("coinc_addr", bus.imem_req_addr, 32'h0000_0320);
        chk("coinc_if_valid", {31'h0, bus.if_valid}, 32'h0);

        // Wrap-around target while in REQ without a handshake.
        redirect(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008);
        chk("wrap_addr", bus.imem_req_addr, 32'h0000_0004);

        // Redirect coincident with an accepted request.
        redirect(1'b1, 1'b0, 32'h0000_0500, 32'h0000_0010);
        chk("reqhs_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        step(1'b0, 1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reqhs_addr", bus.imem_req_addr, 32'h0000_0510);

        // Redirect in HOLD with ID stalled.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("hold_if_pc", bus.if_pc, 32'h0000_0510);
        redirect(1'b0, 1'b0, 32'h0000_0600, 32'h0000_0040);
        chk("hold_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("hold_addr", bus.imem_req_addr, 32'h0000_0640);

        // Reset in the middle of a fetch; a late response is ignored.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("midrst_req_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("midrst_if_instr", bus.if_instr, 32'h0000_0013);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 32'hBAD0_0003, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst_restart", bus.imem_req_addr, 32'h0000_0100);
        chk("midrst_if_valid", {31'h0, bus.if_valid}, 32'h0);

        // Misaligned redirect target.
        redirect(1'b0, 1'b0, 32'h0000_0400, 32'h0000_0002);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", {31'h0, bus.fetch_fault}, 32'h1);
        chk("mis_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        redirect(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000);
        step(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("fault_sticky", {31'h0, bus.fetch_fault}, 32'h1);
        chk("fault_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("fault_cleared", {31'h0, bus.fetch_fault}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
`else
        chk("mis_fault", {31'h0, bus.fetch_fault}, 32'h0);
        fetch_one(32'h0000_0400, 32'h0010_0073);
`endif
        repeat (3) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
